// File: rtl/fp_misc_issue_ctl.sv
// fp_misc_issue_ctl
//   Issue controller for the shared FP sign-inject / min-max / convert
//   datapath. Two issue lanes (i0 older, i1 younger) compete for one
//   operand register (stage A). Stage A drives the combinational datapath
//   through fu_*, and the datapath result is captured in a result
//   register (stage B) that is drained over a valid/ready handshake.
//
// Ports
//   clk, rst_l           core clock, asynchronous active-low reset
//   flush                kill stage A and B, block acceptance this cycle
//   iN_valid/iN_ready    lane request handshake (i0 has fixed priority)
//   iN_ctrl/fp64/rm/lt   op select (one-hot), precision, rounding, compare
//   iN_rs1/rs2/tag       recoded operands and destination tag
//   fu_*                 datapath operands/controls from stage A
//   fu_data/fu_exc       combinational datapath result
//   res_*                result handshake and payload from stage B
//   ops_cnt              saturating count of completed result handshakes
module fp_misc_issue_ctl #(
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst_l,
  input  logic             flush,
  input  logic             i0_valid,
  output logic             i0_ready,
  input  logic [5:0]       i0_ctrl,
  input  logic             i0_fp64,
  input  logic [2:0]       i0_rm,
  input  logic             i0_lt,
  input  logic [64:0]      i0_rs1,
  input  logic [64:0]      i0_rs2,
  input  logic [TAG_W-1:0] i0_tag,
  input  logic             i1_valid,
  output logic             i1_ready,
  input  logic [5:0]       i1_ctrl,
  input  logic             i1_fp64,
  input  logic [2:0]       i1_rm,
  input  logic             i1_lt,
  input  logic [64:0]      i1_rs1,
  input  logic [64:0]      i1_rs2,
  input  logic [TAG_W-1:0] i1_tag,
  output logic [64:0]      fu_in1,
  output logic [64:0]      fu_in2,
  output logic [2:0]       fu_rm,
  output logic             fu_fp64,
  output logic [5:0]       fu_ctrl,
  output logic             fu_lt,
  input  logic [64:0]      fu_data,
  input  logic [4:0]       fu_exc,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [64:0]      res_data,
  output logic [4:0]       res_exc,
  output logic [TAG_W-1:0] res_tag,
  output logic             res_lane,
  output logic [15:0]      ops_cnt
);

  localparam logic [4:0] EXC_NV = 5'b10000;

  typedef struct packed {
    logic             valid;
    logic [64:0]      rs1;
    logic [64:0]      rs2;
    logic [2:0]       rm;
    logic             fp64;
    logic [5:0]       ctrl;     // zeroed when the request ctrl was illegal
    logic             lt;
    logic             illegal;
    logic [TAG_W-1:0] tag;
    logic             lane;
  } stage_a_t;

  typedef struct packed {
    logic             valid;
    logic [64:0]      data;
    logic [4:0]       exc;
    logic [TAG_W-1:0] tag;
    logic             lane;
  } stage_b_t;

  function automatic logic is_onehot(input logic [5:0] c);
    return (c != 6'd0) && ((c & (c - 6'd1)) == 6'd0);
  endfunction

  stage_a_t   a_q, a_d;
  stage_b_t   b_q, b_d;
  logic [15:0] ops_cnt_q, ops_cnt_d;
  // Holds the readies low for the first cycle after reset release.
  logic       rdy_en_q, rdy_en_d;

  logic       res_hs, a_adv, acc, take0, take1;
  logic [5:0] req_ctrl;

  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path
    // can leave a variable unassigned and infer a latch.
    a_d       = a_q;
    b_d       = b_q;
    ops_cnt_d = ops_cnt_q;
    rdy_en_d  = 1'b1;
    req_ctrl  = 6'd0;

    res_hs = b_q.valid & res_ready;
    a_adv  = a_q.valid & (~b_q.valid | res_hs);
    acc    = rdy_en_q & ~flush & (~a_q.valid | a_adv);
    take0  = acc & i0_valid;
    take1  = acc & ~i0_valid & i1_valid;

    // Stage B: reload from the datapath on advance, else drain on handshake.
    if (a_adv) begin
      b_d.valid = 1'b1;
      b_d.data  = a_q.illegal ? 65'd0  : fu_data;
      b_d.exc   = a_q.illegal ? EXC_NV : fu_exc;
      b_d.tag   = a_q.tag;
      b_d.lane  = a_q.lane;
    end else if (res_hs) begin
      b_d.valid = 1'b0;
    end

    // Stage A: new request, else empties when it advances into B.
    if (take0) begin
      a_d.valid   = 1'b1;
      a_d.rs1     = i0_rs1;
      a_d.rs2     = i0_rs2;
      a_d.rm      = i0_rm;
      a_d.fp64    = i0_fp64;
      a_d.lt      = i0_lt;
      a_d.tag     = i0_tag;
      a_d.lane    = 1'b0;
      req_ctrl    = i0_ctrl;
    end else if (take1) begin
      a_d.valid   = 1'b1;
      a_d.rs1     = i1_rs1;
      a_d.rs2     = i1_rs2;
      a_d.rm      = i1_rm;
      a_d.fp64    = i1_fp64;
      a_d.lt      = i1_lt;
      a_d.tag     = i1_tag;
      a_d.lane    = 1'b1;
      req_ctrl    = i1_ctrl;
    end else if (a_adv) begin
      a_d.valid   = 1'b0;
    end
    if (take0 | take1) begin
      a_d.illegal = ~is_onehot(req_ctrl);
      a_d.ctrl    = is_onehot(req_ctrl) ? req_ctrl : 6'd0;
    end

    // A handshake seen during flush is not a completion.
    if (res_hs && !flush && ops_cnt_q != 16'hFFFF) begin
      ops_cnt_d = ops_cnt_q + 16'd1;
    end

    // Flush kills both stages and overrides everything above; payloads
    // are left alone since nothing observes them while invalid.
    if (flush) begin
      a_d.valid = 1'b0;
      b_d       = b_q;
      b_d.valid = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      a_q       <= '0;
      b_q       <= '0;
      ops_cnt_q <= '0;
      rdy_en_q  <= 1'b0;
    end else begin
      a_q       <= a_d;
      b_q       <= b_d;
      ops_cnt_q <= ops_cnt_d;
      rdy_en_q  <= rdy_en_d;
    end
  end

  assign i0_ready  = acc;
  assign i1_ready  = acc & ~i0_valid;

  assign fu_in1    = a_q.rs1;
  assign fu_in2    = a_q.rs2;
  assign fu_rm     = a_q.rm;
  assign fu_fp64   = a_q.fp64;
  assign fu_ctrl   = a_q.ctrl;
  assign fu_lt     = a_q.lt;

  assign res_valid = b_q.valid;
  assign res_data  = b_q.data;
  assign res_exc   = b_q.exc;
  assign res_tag   = b_q.tag;
  assign res_lane  = b_q.lane;
  assign ops_cnt   = ops_cnt_q;

endmodule

// File: doc/fp_misc_issue_ctl.md
# fp_misc_issue_ctl

Issue controller for the shared FP sign-inject / min-max / convert datapath (`FPtoFP`) in the dual-issue FPU. It accepts requests from both issue lanes (i0, i1) over valid/ready handshakes and arbitrates between them. It sequences the winner through a two-stage registered pipeline: an operand register that drives the datapath, and a result register with backpressure. It also supports whole-pipe flush and keeps a saturating completed-op counter.

## Interface
Parameters:
- TAG_W, 5: width of the destination tag carried alongside each operation.

Ports:
- clk  in  1  core clock.
- rst_l  in  1  reset, asynchronous, active-low.
- flush  in  1  kill every in-flight op; block acceptance this cycle.
- i0_valid / i1_valid  in  1  lane request valid.
- i0_ready / i1_ready  out  1  lane request accepted when valid&ready at posedge.
- iN_ctrl  in  6  {fmin, fmax, fsgnj, fsgnjn, fsgnjx, fcvt}; must be one-hot.
- iN_fp64  in  1  double-precision op.
- iN_rm  in  3  rounding mode.
- iN_lt  in  1  rs1<rs2 compare result from the FP compare path.
- iN_rs1, iN_rs2  in  65  recoded operands.
- iN_tag  in  TAG_W  destination tag.
- fu_in1, fu_in2  out  65  datapath operands, driven from the operand register.
- fu_rm  out  3; fu_fp64  out  1; fu_ctrl  out  6; fu_lt  out  1  datapath controls, driven from the operand register.
- fu_data  in  65; fu_exc  in  5  datapath result (combinational from fu_*).
- res_valid  out  1; res_ready  in  1  result handshake.
- res_data  out  65; res_exc  out  5; res_tag  out  TAG_W; res_lane  out  1  (0=i0, 1=i1).
- ops_cnt  out  16  completed-op counter, saturating.

## Operation
- Stage A (operand register): holds a_valid plus all request fields and the source lane. Outputs fu_* come directly from it.
- Stage B (result register): holds b_valid, data, exc, tag and lane. res_* come directly from it.
- Arbitration uses fixed i0 priority, because i0 is older in program order.
  - i0_ready = acc.
  - i1_ready = acc & ~i0_valid.
  - acc = ~flush & (~a_valid | a_adv).
- a_adv = a_valid & (~b_valid | (res_valid & res_ready)). When a_adv is set, B loads {fu_data, fu_exc, tag, lane}.
- B empties on a res handshake unless it is reloaded in the same cycle.
- Illegal ctrl (zero bits or more than one bit set):
  - The request is accepted normally.
  - Stage A drives fu_ctrl=6'b0.
  - B captures res_data=65'b0 and res_exc=5'b10000 (NV).
- flush:
  - Clears a_valid and b_valid at the next edge.
  - Overrides any handshake in that cycle: no accept, and the counter does not increment.
  - res_valid stays as registered during the flush cycle. A consumer handshake in that cycle does not count.
- ops_cnt increments on each res handshake outside flush and saturates at 16'hFFFF.
- Reset values:
  - All valids and readies are 0. i*_ready rises one cycle after reset release.
  - res_data, res_exc, res_tag, res_lane and ops_cnt are 0.
  - fu_* outputs are 0.

## Timing
- Accept at edge N → fu_* valid during cycle N+1 → res_valid high in cycle N+2. Latency is 2 cycles.
- With res_ready held high, throughput is 1 op/cycle and i0_ready stays high.
- With res_ready low:
  - B holds.
  - A holds one more op.
  - The readies drop once A is full and B is full.
  - No op is ever dropped or duplicated.
- When res_ready rises, B drains and A moves into B in the same cycle. The readies return the same cycle, because acc depends combinationally on res_ready.
- fu_* must stay stable while A holds. The datapath is purely combinational, so its output is re-sampled on the advance cycle.
- When i0 and i1 are both valid, i0 wins. i1 is served in the first accept cycle in which i0_valid=0.

## Test plan
- Single op: reset, then i0 fmax fp64 with rs1=65'h0_8000_0000_0000_0000, rs2 smaller, lt=0, tag=3 → res_valid exactly 2 cycles later with res_data=rs1, res_tag=3, res_lane=0, ops_cnt=1.
- Contention: i0 and i1 valid together for 1 cycle, then i1 alone → i1_ready=0 in the first cycle. Results appear lane 0 then lane 1 on consecutive cycles.
- Backpressure: stream 4 ops with res_ready=0 for 5 cycles → readies drop after 2 accepts. After res_ready=1, all 4 results come out in order with no loss, and ops_cnt=4.
- Flush: flush asserted with A and B full and res_ready=1 → next cycle res_valid=0, no accept that cycle, ops_cnt unchanged.
- Illegal ctrl: i1_ctrl=6'b000011 → fu_ctrl=0, res_data=0, res_exc=5'b10000.
- Saturation: force 65536+ handshakes → ops_cnt holds 16'hFFFF. Asserting rst_l low mid-stream clears res_valid and ops_cnt asynchronously.
